vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 82 ++++++++
 tb/tb_vend_controller.sv | 119 +++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// vend_controller: coin-operated vending FSM with credit tracking, dispense and change handshakes.
module vend_controller #(
  parameter int PRICE0     = 5,
  parameter int PRICE1     = 10,
  parameter int PRICE2     = 15,
  parameter int PRICE3     = 20,
  parameter int MAX_CREDIT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] coin_value,
  input  logic       coin_valid,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  input  logic       dispense_ack,
  input  logic       change_ack,
  output logic [7:0] credit,
  output logic       dispense_req,
  output logic [1:0] dispense_id,
  output logic       change_req,
  output logic [7:0] change_value,
  output logic       coin_reject,
  output logic       no_funds,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  state_t     r_state, w_next;
  logic [8:0] w_sum;
  logic [7:0] w_price, w_credit;
  logic [1:0] w_id;
  logic       w_open, w_cancel, w_sel_take, w_sel_refuse, w_coin_take, w_coin_rej;
  assign w_sum        = {1'b0, credit} + {4'b0, coin_value};
  assign w_price      = sel_id == 2'd0 ? 8'(PRICE0) :
                        sel_id == 2'd1 ? 8'(PRICE1) :
                        sel_id == 2'd2 ? 8'(PRICE2) : 8'(PRICE3);
  assign w_open       = r_state == IDLE || r_state == COLLECT;
  assign w_cancel     = cancel && r_state == COLLECT;
  // A selection outranks a coin even when it is refused; the losing coin is rejected.
  assign w_sel_take   = sel_valid && r_state == COLLECT && !cancel && credit >= w_price;
  assign w_sel_refuse = sel_valid && (r_state == IDLE || (r_state == COLLECT && !cancel && credit < w_price));
  assign w_coin_take  = coin_valid && w_open && !w_cancel && !sel_valid && w_sum <= 9'(MAX_CREDIT);
  assign w_coin_rej   = coin_valid && !w_coin_take;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      credit       <= '0;
      dispense_req <= 1'b0;
      dispense_id  <= '0;
      change_req   <= 1'b0;
      change_value <= '0;
      coin_reject  <= 1'b0;
      no_funds     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_next;
      credit       <= w_credit;
      dispense_req <= w_next == DISPENSE;
      dispense_id  <= w_id;
      change_req   <= w_next == CHANGE;
      change_value <= w_next == CHANGE ? w_credit : 8'd0;
      coin_reject  <= w_coin_rej;
      no_funds     <= w_sel_refuse;
      busy         <= w_next == DISPENSE || w_next == CHANGE;
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_coin_take ? COLLECT : IDLE;
      COLLECT:  w_next = w_cancel ? CHANGE : w_sel_take ? DISPENSE : COLLECT;
      DISPENSE: w_next = !dispense_ack ? DISPENSE : credit != 8'd0 ? CHANGE : IDLE;
      CHANGE:   w_next = change_ack ? IDLE : CHANGE;
    endcase
  end
  always_comb begin
    w_credit = w_coin_take ? w_sum[7:0] :
               w_sel_take ? credit - w_price :
               (r_state == CHANGE && change_ack) ? 8'd0 : credit;
    w_id     = w_sel_take ? sel_id : dispense_id;
  end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed self-checking bench for vend_controller.
module tb_vend_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] coin_value = '0;
  logic       coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
  logic       dispense_ack = 1'b0, change_ack = 1'b0;
  logic [1:0] sel_id = '0;
  logic [7:0] credit, change_value;
  logic       dispense_req, change_req, coin_reject, no_funds, busy;
  logic [1:0] dispense_id;
  int checks = 0, errors = 0;
  vend_controller dut (
    .clk(clk), .rst_n(rst_n), .coin_value(coin_value), .coin_valid(coin_valid),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .dispense_ack(dispense_ack), .change_ack(change_ack), .credit(credit),
    .dispense_req(dispense_req), .dispense_id(dispense_id), .change_req(change_req),
    .change_value(change_value), .coin_reject(coin_reject), .no_funds(no_funds), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    coin_valid = 0; sel_valid = 0; cancel = 0; dispense_ack = 0; change_ack = 0;
  endtask
  task automatic coin(input int v);
    coin_value = 5'(v); coin_valid = 1; cyc();
  endtask
  task automatic sel(input int id);
    sel_id = 2'(id); sel_valid = 1; cyc();
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_dreq"}, dispense_req, 0);
    chk({tag, "_did"}, dispense_id, 0);
    chk({tag, "_creq"}, change_req, 0);
    chk({tag, "_cval"}, change_value, 0);
    chk({tag, "_crej"}, coin_reject, 0);
    chk({tag, "_nof"}, no_funds, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    cyc(); cyc();
    all_zero("reset");
    rst_n = 1;
    cancel = 1; cyc();
    chk("idle_cancel_creq", change_req, 0);
    change_ack = 1; dispense_ack = 1; cyc();
    chk("idle_acks_busy", busy, 0);
    // Scenario 1
    coin(5);  chk("s1_credit5", credit, 5);
    coin(10); chk("s1_credit15", credit, 15);
    sel(1);
    chk("s1_dreq", dispense_req, 1); chk("s1_did", dispense_id, 1);
    chk("s1_credit_after_sel", credit, 5); chk("s1_busy", busy, 1);
    cyc(); chk("s1_dreq_hold", dispense_req, 1);
    dispense_ack = 1; cyc();
    chk("s1_dreq_drop", dispense_req, 0); chk("s1_creq", change_req, 1);
    chk("s1_cval", change_value, 5);
    cyc(); chk("s1_creq_hold", change_req, 1);
    change_ack = 1; cyc();
    chk("s1_creq_drop", change_req, 0); chk("s1_credit0", credit, 0);
    chk("s1_cval0", change_value, 0); chk("s1_busy0", busy, 0);
    // Scenario 2
    coin(5); sel(3);
    chk("s2_nof", no_funds, 1); chk("s2_credit", credit, 5); chk("s2_dreq", dispense_req, 0);
    cyc(); chk("s2_nof_pulse", no_funds, 0);
    change_ack = 1; cyc(); chk("s2_stray_cack_credit", credit, 5);
    cancel = 1; cyc();
    chk("s2_cancel_creq", change_req, 1); chk("s2_cancel_cval", change_value, 5);
    change_ack = 1; cyc(); chk("s2_idle_credit", credit, 0);
    // Scenario 3 and credit ceiling
    for (int i = 0; i < 9; i++) coin(10);
    coin(5); chk("s3_credit95", credit, 95);
    coin(10);
    chk("s3_crej", coin_reject, 1); chk("s3_credit_kept", credit, 95);
    coin(1);
    chk("s3_credit96", credit, 96); chk("s3_crej_clear", coin_reject, 0);
    coin(1); coin(1); coin(1);
    chk("s3_credit99", credit, 99); chk("s3_crej99", coin_reject, 0);
    coin(1);
    chk("s3_crej100", coin_reject, 1); chk("s3_credit_max", credit, 99);
    cancel = 1; coin_value = 5'd1; coin_valid = 1; cyc();
    chk("s3_cancel_coin_rej", coin_reject, 1); chk("s3_cval99", change_value, 99);
    change_ack = 1; cyc();
    // Scenario 4
    coin(10);
    cancel = 1; sel_valid = 1; sel_id = 2'd0; cyc();
    chk("s4_creq", change_req, 1); chk("s4_cval", change_value, 10);
    chk("s4_dreq", dispense_req, 0); chk("s4_nof", no_funds, 0);
    change_ack = 1; cyc(); chk("s4_idle", credit, 0);
    // Scenario 5
    coin(10); sel(1);
    chk("s5_dreq", dispense_req, 1); chk("s5_credit0", credit, 0);
    coin(5);
    chk("s5_crej", coin_reject, 1); chk("s5_credit_kept", credit, 0);
    change_ack = 1; cyc(); chk("s5_stray_cack_dreq", dispense_req, 1);
    dispense_ack = 1; cyc();
    chk("s5_dreq_drop", dispense_req, 0); chk("s5_no_creq", change_req, 0);
    chk("s5_busy0", busy, 0);
    // Scenario 6
    coin(20); sel(2);
    chk("s6_dreq", dispense_req, 1); chk("s6_did", dispense_id, 2);
    rst_n = 0; cyc();
    all_zero("s6_reset");
    rst_n = 1;
    sel(0); chk("s6_idle_nof", no_funds, 1);
    coin(5); chk("s6_idle_coin", credit, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
